// File: rtl/pacman_soc_nios2_processor_cpu_mult_seq_if.sv
// rtl/pacman_soc_nios2_processor_cpu_mult_seq_if.sv - request/response handshake bundle for the multiply sequencer
interface pacman_soc_nios2_processor_cpu_mult_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_unimpl;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_unimpl
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_unimpl
    );
endinterface

// File: rtl/pacman_soc_nios2_processor_cpu_mult_seq.sv
// rtl/pacman_soc_nios2_processor_cpu_mult_seq.sv - sequencer for the 16x16 three-product multiply cell
// Optional high-word ops (MULXUU/MULXSS/MULXSU) enabled by defining MULT_SEQ_HIGH_WORD_EN.
module pacman_soc_nios2_processor_cpu_mult_seq #(
    parameter int ACCEPT_IN_RESP = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    pacman_soc_nios2_processor_cpu_mult_seq_if.slave bus,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
`ifdef MULT_SEQ_HIGH_WORD_EN
        S_P2,
`endif
        S_RESP
    } state_t;

    localparam logic [1:0] OP_MUL = 2'b00;

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [31:0] result_q, result_d;
    logic        accept;
    logic        req_ready;

    // Low word: p1 + ((p2 + p3) << 16); the upper 17 bits are the carry into the high word.
    logic [32:0] p23;
    logic [48:0] sum;
    assign p23 = {1'b0, cell_p2} + {1'b0, cell_p3};
    assign sum = {17'b0, cell_p1} + ({16'b0, p23} << 16);

`ifdef MULT_SEQ_HIGH_WORD_EN
    logic [16:0] carry_q, carry_d;
    logic [31:0] uhi, corr_a, corr_b, hi_word;

    // Signed forms are the unsigned high word minus the two's-complement sign corrections.
    assign uhi    = cell_p1 + {15'b0, carry_q};
    assign corr_a = a_q[31] ? b_q : 32'd0;
    assign corr_b = b_q[31] ? a_q : 32'd0;

    always_comb begin
        hi_word = uhi;
        case (op_q)
            2'b10:   hi_word = uhi - corr_a - corr_b;
            2'b11:   hi_word = uhi - corr_a;
            default: hi_word = uhi;
        endcase
    end

    assign bus.rsp_unimpl = 1'b0;
`else
    logic unimpl_q, unimpl_d;
    logic unused_hi;
    assign unused_hi      = ^sum[48:32];
    assign bus.rsp_unimpl = unimpl_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 2'b00;
            result_q <= 32'd0;
`ifdef MULT_SEQ_HIGH_WORD_EN
            carry_q  <= 17'd0;
`else
            unimpl_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifdef MULT_SEQ_HIGH_WORD_EN
            carry_q  <= carry_d;
`else
            unimpl_q <= unimpl_d;
`endif
            if (accept) begin
                a_q  <= bus.req_src1;
                b_q  <= bus.req_src2;
                op_q <= bus.req_op;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        cell_en   = 1'b0;
        cell_src1 = 32'd0;
        cell_src2 = 32'd0;
`ifdef MULT_SEQ_HIGH_WORD_EN
        carry_d   = carry_q;
`else
        unimpl_d  = unimpl_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = S_P0;
                end
            end
            S_P0: begin
                cell_en   = 1'b1;
                cell_src1 = a_q;
                cell_src2 = b_q;
                state_d   = S_P1;
            end
            S_P1: begin
                if (op_q == OP_MUL) begin
                    result_d = sum[31:0];
`ifndef MULT_SEQ_HIGH_WORD_EN
                    unimpl_d = 1'b0;
`endif
                    state_d  = S_RESP;
                end else begin
`ifdef MULT_SEQ_HIGH_WORD_EN
                    carry_d   = sum[48:32];
                    cell_en   = 1'b1;
                    cell_src1 = {16'b0, a_q[31:16]};
                    cell_src2 = {16'b0, b_q[31:16]};
                    state_d   = S_P2;
`else
                    result_d  = 32'd0;
                    unimpl_d  = 1'b1;
                    state_d   = S_RESP;
`endif
                end
            end
`ifdef MULT_SEQ_HIGH_WORD_EN
            S_P2: begin
                result_d = hi_word;
                state_d  = S_RESP;
            end
`endif
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    // Back-to-back: retire the response and latch the next op on the same edge.
                    if (ACCEPT_IN_RESP != 0) begin
                        req_ready = 1'b1;
                        if (bus.req_valid) begin
                            accept  = 1'b1;
                            state_d = S_P0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_result = result_q;

endmodule

// File: tb/tb_pacman_soc_nios2_processor_cpu_mult_seq.sv
// tb/tb_pacman_soc_nios2_processor_cpu_mult_seq.sv - directed self-checking bench for the multiply sequencer
module tb_pacman_soc_nios2_processor_cpu_mult_seq;

    logic        clk;
    logic        reset_n;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;
    int          errors;
    int          checks;

`ifdef MULT_SEQ_HIGH_WORD_EN
    localparam int HI_LAT = 4;
    localparam int HI_EN  = 2;
`else
    localparam int HI_LAT = 3;
    localparam int HI_EN  = 1;
`endif

    pacman_soc_nios2_processor_cpu_mult_seq_if bus ();

    pacman_soc_nios2_processor_cpu_mult_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural three-product cell: products register at the edge ending an en=1 cycle.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
            cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
            cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
        end
    end

    // Issues one op, returns at the negedge where rsp_valid is first seen (or the budget expires).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit release_rsp, output int lat, output int en_cnt,
                         output logic [31:0] res, output logic unimpl);
        int w;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.rsp_ready = 1'b0;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        lat    = 0;
        en_cnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.req_op    = 2'b11;
            bus.req_src1  = 32'hDEAD_BEEF;
            bus.req_src2  = 32'hCAFE_F00D;
            lat++;
            if (cell_en) en_cnt++;
            if (bus.rsp_valid) break;
        end
        res    = bus.rsp_result;
        unimpl = bus.rsp_unimpl;
        if (release_rsp) begin
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_src1  = 32'd0;
        bus.req_src2  = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", bus.rsp_result); end
        checks++; if (bus.rsp_unimpl !== 1'b0) begin errors++; $display("FAIL reset_rsp_unimpl got %b want 0", bus.rsp_unimpl); end
        checks++; if (cell_en !== 1'b0) begin errors++; $display("FAIL reset_cell_en got %b want 0", cell_en); end
        checks++; if (cell_src1 !== 32'd0 || cell_src2 !== 32'd0) begin errors++; $display("FAIL reset_cell_src got %h/%h want 0/0", cell_src1, cell_src2); end
        reset_n = 1'b1;
        @(negedge clk);
        // rsp_ready with no response pending must be ignored
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_mul;
        int lat, en;
        logic [31:0] res;
        logic un;
        do_op(2'b00, 32'd7, 32'd6, 1'b1, lat, en, res, un);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mul7x6_latency got %0d want 3", lat); end
        checks++; if (en !== 1) begin errors++; $display("FAIL mul7x6_cell_en got %0d want 1", en); end
        checks++; if (res !== 32'h0000_002A) begin errors++; $display("FAIL mul7x6_result got %h want 0000002a", res); end
        checks++; if (un !== 1'b0) begin errors++; $display("FAIL mul7x6_unimpl got %b want 0", un); end
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, en, res, un);
        checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL mul_ones_result got %h want 00000001", res); end
        do_op(2'b00, 32'h0001_0001, 32'h0001_0001, 1'b1, lat, en, res, un);
        checks++; if (res !== 32'h0002_0001) begin errors++; $display("FAIL mul_cross_result got %h want 00020001", res); end
        do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b1, lat, en, res, un);
        checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL mul_2p32_result got %h want 00000000", res); end
    endtask

    task automatic test_high_ops;
        int lat, en;
        logic [31:0] res;
        logic un;
        logic [1:0]  ops [6]  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
        logic [31:0] as  [6]  = '{32'hFFFF_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000};
        logic [31:0] bs  [6]  = '{32'hFFFF_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000};
`ifdef MULT_SEQ_HIGH_WORD_EN
        logic [31:0] exp [6]  = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        logic        exp_un   = 1'b0;
`else
        logic [31:0] exp [6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic        exp_un   = 1'b1;
`endif
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b1, lat, en, res, un);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL high_op%0d_result got %h want %h", i, res, exp[i]); end
            checks++; if (un !== exp_un) begin errors++; $display("FAIL high_op%0d_unimpl got %b want %b", i, un, exp_un); end
            checks++; if (lat !== HI_LAT) begin errors++; $display("FAIL high_op%0d_latency got %0d want %0d", i, lat, HI_LAT); end
            checks++; if (en !== HI_EN) begin errors++; $display("FAIL high_op%0d_cell_en got %0d want %0d", i, en, HI_EN); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, en;
        logic [31:0] res;
        logic un;
        do_op(2'b00, 32'h0000_1234, 32'h0000_0010, 1'b0, lat, en, res, un);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_src1  = 32'd4;
        bus.req_src2  = 32'd5;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_rsp_valid got %b want 1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_result !== 32'h0001_2340) begin errors++; $display("FAIL hold%0d_result got %h want 00012340", i, bus.rsp_result); end
            checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_req_ready got %b want 0", i, bus.req_ready); end
            checks++; if (cell_en !== 1'b0) begin errors++; $display("FAIL hold%0d_cell_en got %b want 0", i, cell_en); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL retire_state got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.rsp_valid) break;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL next_op_latency got %0d want 3", lat); end
        checks++; if (bus.rsp_result !== 32'h0000_0014) begin errors++; $display("FAIL next_op_result got %h want 00000014", bus.rsp_result); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int lat, en, rises;
        logic [31:0] res;
        logic un;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_src1  = 32'hFFFF_FFFF;
        bus.req_src2  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || cell_en !== 1'b0) begin errors++; $display("FAIL midreset_outputs got valid=%b en=%b want 0/0", bus.rsp_valid, cell_en); end
        checks++; if (bus.rsp_result !== 32'd0 || cell_src1 !== 32'd0) begin errors++; $display("FAIL midreset_data got result=%h src1=%h want 0/0", bus.rsp_result, cell_src1); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rises = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) rises++;
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL midreset_no_response got %0d valid cycles want 0", rises); end
        do_op(2'b00, 32'd3, 32'd5, 1'b1, lat, en, res, un);
        checks++; if (res !== 32'h0000_000F || lat !== 3) begin errors++; $display("FAIL post_reset_mul got %h lat %0d want 0000000f lat 3", res, lat); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mul();
        test_high_ops();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
